// File: rtl/i2s_pkg.sv
// Shared constants and types for the 2x I2S upsampler timing controller.
package i2s_pkg;

  localparam int SLOT_BITS = 16;
  localparam int BIT_IDX_W = $clog2(SLOT_BITS);
  localparam int PHASE_W   = 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    MEASURE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  // Decoded slot start request for the current phase.
  typedef struct packed {
    logic start;
    logic side;   // 0 = L, 1 = R
  } slot_req_t;

  function automatic logic [PHASE_W-1:0] abs_diff(input logic [PHASE_W-1:0] a,
                                                  input logic [PHASE_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/i2s_frame_meter.sv
// WS falling-edge detector, saturating frame phase counter, frame length
// measurement and the match/lock state machine.
module i2s_frame_meter
  import i2s_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int FRAME_TOL   = 2,
  parameter int MIN_FRAME   = 64
) (
  input  logic       I2S_BCK,
  input  logic       reset,
  input  logic       I2S_WS,
  output logic [7:0] phase,
  output logic [7:0] frame_len,
  output logic [7:0] lock_len,
  output logic       locked,
  output logic       lock_nxt,
  output logic       unlock_evt
);

  localparam logic [7:0] TOL8      = 8'(FRAME_TOL);
  localparam logic [7:0] MIN8      = 8'(MIN_FRAME);
  localparam logic [7:0] LAST_CNT8 = 8'(LOCK_FRAMES - 1);
  localparam logic [7:0] PH_MAX    = 8'hFF;

  logic        ws_prev;
  logic        wsfall;
  logic [7:0]  len;
  logic        len_match;
  logic [7:0]  match_cnt, match_cnt_nxt;
  logic [7:0]  lock_len_nxt;
  lock_state_e state, state_nxt;

  assign wsfall    = ws_prev & ~I2S_WS;
  // A saturated phase means the frame is at least 256 long; report 255.
  assign len       = (phase == PH_MAX) ? PH_MAX : phase + 8'd1;
  assign len_match = (len >= MIN8) && (len == frame_len);
  assign locked    = (state == LOCKED);
  assign lock_nxt  = (state_nxt == LOCKED);

  // WS history and frame phase (cleared on wsfall, saturating at 255)
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) begin
      ws_prev <= 1'b0;
      phase   <= '0;
    end else begin
      ws_prev <= I2S_WS;
      if (wsfall)
        phase <= '0;
      else if (phase != PH_MAX)
        phase <= phase + 8'd1;
    end
  end

  // Lock FSM next state: count matching frames, drop lock on drift or lost WS
  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    lock_len_nxt  = lock_len;
    unlock_evt    = 1'b0;
    case (state)
      UNLOCKED: begin
        if (wsfall) begin
          state_nxt     = MEASURE;
          match_cnt_nxt = '0;
        end
      end
      MEASURE: begin
        if (wsfall) begin
          if (len_match) begin
            if (match_cnt == LAST_CNT8) begin
              state_nxt     = LOCKED;
              lock_len_nxt  = len;
              match_cnt_nxt = '0;
            end else begin
              match_cnt_nxt = match_cnt + 8'd1;
            end
          end else begin
            match_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if ((wsfall && (abs_diff(len, lock_len) > TOL8)) || (phase == PH_MAX)) begin
          state_nxt     = MEASURE;
          match_cnt_nxt = '0;
          unlock_evt    = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // FSM state, match counter, lock length and measured frame length
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      lock_len  <= '0;
      frame_len <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
      lock_len  <= lock_len_nxt;
      // The first edge after reset has no prior edge to measure from.
      if (wsfall && (state != UNLOCKED))
        frame_len <= len;
    end
  end

endmodule

// File: rtl/i2s_2x_scheduler.sv
// Timing controller for the 2x I2S upsampler (I2S_BCK domain). Schedules four
// 16-bit slots (L,R,L,R) per locked input frame and the buffer ping-pong.
// Optional: define I2S_SCHED_STATS_EN to add unlock_cnt / frame_len_max.
module i2s_2x_scheduler
  import i2s_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int FRAME_TOL   = 2,
  parameter int SWAP_BACK   = 31,
  parameter int MIN_FRAME   = 64
) (
  input  logic       I2S_BCK,
  input  logic       reset,
  input  logic       I2S_WS,
  output logic       ws_2x,
  output logic       bit_valid,
  output logic [3:0] bit_idx,
  output logic       rd_buf_idx,
  output logic       bck_gate,
  output logic       locked,
  output logic [7:0] frame_len
`ifdef I2S_SCHED_STATS_EN
  ,
  output logic [7:0] unlock_cnt,
  output logic [7:0] frame_len_max
`endif
);

  localparam logic [BIT_IDX_W-1:0] IDX_TOP = BIT_IDX_W'(SLOT_BITS - 1);

  logic [7:0] phase;
  logic [7:0] lock_len;
  logic       lock_nxt;
  logic       unlock_evt;
  logic [7:0] ph_h, ph_q, ph_hq, swap_ph;
  slot_req_t  req;

  i2s_frame_meter #(
    .LOCK_FRAMES (LOCK_FRAMES),
    .FRAME_TOL   (FRAME_TOL),
    .MIN_FRAME   (MIN_FRAME)
  ) u_meter (
    .I2S_BCK    (I2S_BCK),
    .reset      (reset),
    .I2S_WS     (I2S_WS),
    .phase      (phase),
    .frame_len  (frame_len),
    .lock_len   (lock_len),
    .locked     (locked),
    .lock_nxt   (lock_nxt),
    .unlock_evt (unlock_evt)
  );

  // Slot phases from the locked length; an odd trailing cycle lands after the last R slot.
  assign ph_h    = {1'b0, lock_len[7:1]};
  assign ph_q    = {2'b00, lock_len[7:2]};
  assign ph_hq   = ph_h + ph_q;
  assign swap_ph = lock_len - 8'(SWAP_BACK);

  // Decode slot starts from the current phase while locked
  always_comb begin
    req = '0;
    if (locked) begin
      if ((phase == 8'd0) || (phase == ph_h)) begin
        req.start = 1'b1;
        req.side  = 1'b0;
      end else if ((phase == ph_q) || (phase == ph_hq)) begin
        req.start = 1'b1;
        req.side  = 1'b1;
      end
    end
  end

  // Slot sequencer: start (truncating any slot in flight), count bits down, abort on unlock
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) begin
      ws_2x     <= 1'b0;
      bit_valid <= 1'b0;
      bit_idx   <= '0;
      bck_gate  <= 1'b0;
    end else if (!lock_nxt) begin
      // Leaving lock kills the slot in the same edge that drops 'locked'.
      bit_valid <= 1'b0;
      bck_gate  <= 1'b0;
    end else if (req.start) begin
      ws_2x     <= req.side;
      bit_valid <= 1'b1;
      bit_idx   <= IDX_TOP;
      bck_gate  <= 1'b1;
    end else if (bit_valid) begin
      if (bit_idx == '0) begin
        bit_valid <= 1'b0;
        bck_gate  <= 1'b0;
      end else begin
        bit_idx <= bit_idx - 4'd1;
      end
    end
  end

  // Ping-pong buffer swap once per locked frame, late enough for the writer to finish
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset)
      rd_buf_idx <= 1'b0;
    else if (locked && (phase == swap_ph))
      rd_buf_idx <= ~rd_buf_idx;
  end

`ifdef I2S_SCHED_STATS_EN
  // Saturating unlock counter and running maximum of the measured frame length
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) begin
      unlock_cnt    <= '0;
      frame_len_max <= '0;
    end else begin
      if (unlock_evt && (unlock_cnt != 8'hFF))
        unlock_cnt <= unlock_cnt + 8'd1;
      if (frame_len > frame_len_max)
        frame_len_max <= frame_len;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = unlock_evt;
`endif

endmodule

// File: tb/tb_i2s_2x_scheduler.sv
// Directed bench for i2s_2x_scheduler. Define I2S_SCHED_STATS_EN to also
// exercise the statistics ports.
module tb_i2s_2x_scheduler;

  logic       I2S_BCK = 1'b0;
  logic       reset;
  logic       I2S_WS;
  logic       ws_2x, bit_valid, rd_buf_idx, bck_gate, locked;
  logic [3:0] bit_idx;
  logic [7:0] frame_len;
`ifdef I2S_SCHED_STATS_EN
  logic [7:0] unlock_cnt, frame_len_max;
`endif

  int n_vec = 0;
  int n_err = 0;

  i2s_2x_scheduler dut (
    .I2S_BCK    (I2S_BCK),
    .reset      (reset),
    .I2S_WS     (I2S_WS),
    .ws_2x      (ws_2x),
    .bit_valid  (bit_valid),
    .bit_idx    (bit_idx),
    .rd_buf_idx (rd_buf_idx),
    .bck_gate   (bck_gate),
    .locked     (locked),
    .frame_len  (frame_len)
`ifdef I2S_SCHED_STATS_EN
    ,
    .unlock_cnt    (unlock_cnt),
    .frame_len_max (frame_len_max)
`endif
  );

  always #5 I2S_BCK = ~I2S_BCK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One BCK cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge I2S_BCK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ws_2x"},      8'(ws_2x),      8'd0);
    chk({tag, ".bit_valid"},  8'(bit_valid),  8'd0);
    chk({tag, ".bit_idx"},    8'(bit_idx),    8'd0);
    chk({tag, ".rd_buf_idx"}, 8'(rd_buf_idx), 8'd0);
    chk({tag, ".bck_gate"},   8'(bck_gate),   8'd0);
    chk({tag, ".locked"},     8'(locked),     8'd0);
    chk({tag, ".frame_len"},  frame_len,      8'd0);
`ifdef I2S_SCHED_STATS_EN
    chk({tag, ".unlock_cnt"}, unlock_cnt,     8'd0);
`endif
  endtask

  // One WS frame: lo cycles low (first cycle is the falling edge), hi cycles high.
  // Sample c is taken after the edge at which the frame phase equals c.
  // mode 0: drive only; 1: check the locked schedule for lock length ll;
  // 2: check that nothing is scheduled and lock is off.
  task automatic run_frame(input int lo, input int hi, input int mode,
                           input int ll, input logic rd0, input logic ws0);
    int   st[4];
    int   d;
    logic ev, ew, er;
    logic [3:0] ei;
    st = '{0, ll / 4, ll / 2, ll / 2 + ll / 4};
    for (int c = 0; c < lo + hi; c++) begin
      I2S_WS = (c < lo) ? 1'b0 : 1'b1;
      tick();
      if (mode == 1) begin
        ew = ws0; ev = 1'b0; ei = 4'd0;
        for (int k = 0; k < 4; k++) begin
          if (st[k] + 1 <= c) begin
            ew = (k % 2 == 1);
            d  = c - st[k] - 1;
            ev = (d < 16);
            ei = ev ? 4'(15 - d) : 4'd0;
          end
        end
        // Swap matches at phase ll-31, visible one cycle later.
        er = rd0 ^ (c >= ll - 30);
        chk($sformatf("locked@%0d", c),    8'(locked),     8'(c <= 255));
        chk($sformatf("bit_valid@%0d", c), 8'(bit_valid),  8'(ev));
        chk($sformatf("bck_gate@%0d", c),  8'(bck_gate),   8'(ev));
        chk($sformatf("bit_idx@%0d", c),   8'(bit_idx),    8'(ei));
        chk($sformatf("ws_2x@%0d", c),     8'(ws_2x),      8'(ew));
        chk($sformatf("rd_buf@%0d", c),    8'(rd_buf_idx), 8'(er));
      end else if (mode == 2) begin
        chk($sformatf("idle.locked@%0d", c),    8'(locked),    8'd0);
        chk($sformatf("idle.bit_valid@%0d", c), 8'(bit_valid), 8'd0);
        chk($sformatf("idle.bck_gate@%0d", c),  8'(bck_gate),  8'd0);
      end
    end
  endtask

  // WS high briefly, then five unchecked frames; lock lands on the next fall.
  task automatic lock_seq(input int lo, input int hi);
    I2S_WS = 1'b1;
    repeat (4) tick();
    repeat (5) run_frame(lo, hi, 0, 0, 1'b0, 1'b0);
    chk("pre_lock.locked", 8'(locked), 8'd0);
  endtask

  initial begin
    // Reset state
    reset  = 1'b1;
    I2S_WS = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Lock to 208 and check two full frames of slot timing
    lock_seq(104, 104);
    chk("t1.frame_len", frame_len, 8'd208);
    run_frame(104, 104, 1, 208, 1'b0, 1'b0);
    run_frame(104, 104, 1, 208, 1'b1, 1'b1);

    // Jitter: 207 stays locked, 211 drops lock, relock after four 211 frames
    run_frame(103, 104, 1, 208, 1'b0, 1'b1);
    run_frame(105, 106, 1, 208, 1'b1, 1'b1);
    chk("t3.frame_len207", frame_len, 8'd207);
    run_frame(105, 106, 2, 0, 1'b0, 1'b0);
    chk("t3.frame_len211", frame_len, 8'd211);
`ifdef I2S_SCHED_STATS_EN
    chk("t3.unlock_cnt", unlock_cnt, 8'd1);
    chk("t3.frame_len_max", frame_len_max, 8'd211);
`endif
    repeat (3) run_frame(105, 106, 2, 0, 1'b0, 1'b0);
    run_frame(105, 106, 1, 211, 1'b0, 1'b1);

    // WS held low 300 cycles: phase saturates, lock drops after phase 255
    run_frame(300, 10, 1, 211, 1'b1, 1'b1);
`ifdef I2S_SCHED_STATS_EN
    chk("t5.unlock_cnt", unlock_cnt, 8'd2);
`endif
    I2S_WS = 1'b0;
    tick();
    chk("t5.frame_len_sat", frame_len, 8'd255);
    chk("t5.locked", 8'(locked), 8'd0);

    // Relock at 208, then async reset in the middle of the first L slot
    lock_seq(104, 104);
    for (int c = 0; c < 10; c++) begin
      I2S_WS = 1'b0;
      tick();
    end
    chk("t6.locked", 8'(locked), 8'd1);
    chk("t6.bit_valid", 8'(bit_valid), 8'd1);
    chk("t6.bit_idx", 8'(bit_idx), 8'd7);
    #2 reset = 1'b1;
    #1 chk_reset_vals("t6.async");
    repeat (3) tick();
    reset = 1'b0;
    lock_seq(104, 104);
    run_frame(104, 104, 1, 208, 1'b0, 1'b0);

    // Frames of 40 never lock
    run_frame(20, 20, 0, 0, 1'b0, 1'b0);
    repeat (5) run_frame(20, 20, 2, 0, 1'b0, 1'b0);
    chk("t4.frame_len", frame_len, 8'd40);

    // Shortest valid frame (64) locks; slots at 0/16/32/48
    lock_seq(32, 32);
    run_frame(32, 32, 1, 64, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
